// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the Nios II debug-slave virtual-JTAG host.
package nios_dbg_pkg;

  localparam int NIOS_DBG_SR_W = 38;

  localparam logic [1:0] NIOS_DBG_IR_OCIMEM    = 2'd0;
  localparam logic [1:0] NIOS_DBG_IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] NIOS_DBG_IR_BREAK     = 2'd2;
  localparam logic [1:0] NIOS_DBG_IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_t;

endpackage

// File: rtl/nios_dbg_jtag_host_if.sv
// Command/response handshake between a debug master and the JTAG host.
interface nios_dbg_jtag_host_if
  import nios_dbg_pkg::*;
#(
  parameter int SR_W = NIOS_DBG_SR_W
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_ir;
  logic [SR_W-1:0] req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [SR_W-1:0] rsp_data;

  modport master (
    output req_valid, req_ir, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_ir, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios_dbg_tck_gen.sv
// Test-clock generator: tck toggles every TCK_DIV clk while running.
// rise_pulse/fall_pulse flag the clk edge on which tck is about to toggle.
module nios_dbg_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] phase;
  logic          wrap;

  assign wrap       = run && !clear && (phase == LAST);
  assign rise_pulse = wrap && !tck;
  assign fall_pulse = wrap && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (clear) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        phase <= '0;
        tck   <= ~tck;
      end else begin
        phase <= phase + CW'(1);
      end
    end
  end
endmodule

// File: rtl/nios_dbg_jtag_host.sv
// Virtual-JTAG initiator for the Nios II debug slave: one command -> UIR, CDR, SDR, UDR, RTI.
// Optional NIOS_DBG_HOST_IR_SKIP_EN skips UIR when the IR matches the last one issued.
//
// state   | meaning
// IDLE    | waiting for a command, req_ready high
// UIR     | one tck period with vji_uir high
// CDR     | one tck period with vji_cdr high
// SDR     | SR_W tck periods shifting tdi out / tdo in
// UDR     | one tck period with vji_udr high
// RTI     | one tck period with vji_rti high, then capture response
// RESP    | rsp_valid held until rsp_ready
module nios_dbg_jtag_host
  import nios_dbg_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int SR_W    = NIOS_DBG_SR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_dbg_jtag_host_if.slave  host,
  output logic                 vji_tck,
  output logic                 vji_tdi,
  input  logic                 vji_tdo,
  output logic [1:0]           vji_ir_in,
  output logic                 vji_uir,
  output logic                 vji_cdr,
  output logic                 vji_sdr,
  output logic                 vji_udr,
  output logic                 vji_rti
);
  localparam int BW = $clog2(SR_W + 1);

  state_t          state;
  logic [SR_W-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic            tck_run;
  logic            tck_rise;
  logic            tck_fall;
  logic            accept;
  logic            ir_skip;

  assign accept  = host.req_valid && host.req_ready;
  assign tck_run = (state != ST_IDLE) && (state != ST_RESP);

  nios_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (tck_run),
    .clear      (!tck_run),
    .tck        (vji_tck),
    .rise_pulse (tck_rise),
    .fall_pulse (tck_fall)
  );

`ifdef NIOS_DBG_HOST_IR_SKIP_EN
  // vji_ir_in already holds the last IR; only its validity needs tracking.
  logic ir_known;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    ir_known <= 1'b0;
    else if (accept) ir_known <= 1'b1;
  end
  assign ir_skip = ir_known && (host.req_ir == vji_ir_in);
`else
  assign ir_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      vji_tdi        <= 1'b0;
      vji_ir_in      <= 2'd0;
      vji_uir        <= 1'b0;
      vji_cdr        <= 1'b0;
      vji_sdr        <= 1'b0;
      vji_udr        <= 1'b0;
      vji_rti        <= 1'b0;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          host.req_ready <= 1'b1;
          if (accept) begin
            host.req_ready <= 1'b0;
            vji_ir_in      <= host.req_ir;
            shreg          <= host.req_data;
            bit_cnt        <= '0;
            if (ir_skip) begin
              state   <= ST_CDR;
              vji_cdr <= 1'b1;
            end else begin
              state   <= ST_UIR;
              vji_uir <= 1'b1;
            end
          end
        end
        ST_UIR: if (tck_fall) begin
          state   <= ST_CDR;
          vji_uir <= 1'b0;
          vji_cdr <= 1'b1;
        end
        ST_CDR: if (tck_fall) begin
          state   <= ST_SDR;
          vji_cdr <= 1'b0;
          vji_sdr <= 1'b1;
          vji_tdi <= shreg[0];
        end
        ST_SDR: begin
          if (tck_rise) begin
            shreg   <= {vji_tdo, shreg[SR_W-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (tck_fall) begin
            if (bit_cnt == BW'(SR_W)) begin
              state   <= ST_UDR;
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi <= shreg[0];
            end
          end
        end
        ST_UDR: if (tck_fall) begin
          state   <= ST_RTI;
          vji_udr <= 1'b0;
          vji_rti <= 1'b1;
        end
        ST_RTI: if (tck_fall) begin
          state         <= ST_RESP;
          vji_rti       <= 1'b0;
          host.rsp_data <= shreg;
        end
        ST_RESP: begin
          // rsp_valid rises one clk after capture so rsp_data is settled first.
          if (!host.rsp_valid) begin
            host.rsp_valid <= 1'b1;
          end else if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            host.req_ready <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios_dbg_jtag_host.sv
// Directed bench for nios_dbg_jtag_host: TCK_DIV=4 and TCK_DIV=1 instances, behavioural debug slave.
module tb_nios_dbg_jtag_host;
  import nios_dbg_pkg::*;

  localparam int SR_W = NIOS_DBG_SR_W;
`ifdef NIOS_DBG_HOST_IR_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  nios_dbg_jtag_host_if #(.SR_W(SR_W)) h0 ();
  nios_dbg_jtag_host_if #(.SR_W(SR_W)) h1 ();

  logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic [1:0] ir0;
  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] ir1;

  nios_dbg_jtag_host #(.TCK_DIV(4), .SR_W(SR_W)) dut (
    .clk(clk), .reset_n(reset_n), .host(h0),
    .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0), .vji_ir_in(ir0),
    .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
  );

  nios_dbg_jtag_host #(.TCK_DIV(1), .SR_W(SR_W)) dut_fast (
    .clk(clk), .reset_n(reset_n), .host(h1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
  );

  // Behavioural debug slave: shifts only during SDR.
  logic [SR_W-1:0] slv_sr, slv_init;
  logic            slv_load, tdo_tie;
  always @(posedge tck0 or posedge slv_load)
    if (slv_load)  slv_sr <= slv_init;
    else if (sdr0) slv_sr <= {tdi0, slv_sr[SR_W-1:1]};
  assign tdo0 = tdo_tie ? 1'b1 : slv_sr[0];
  assign tdo1 = 1'b1;

  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
  always @(posedge tck0) begin
    n_uir <= n_uir + int'(uir0);
    n_cdr <= n_cdr + int'(cdr0);
    n_sdr <= n_sdr + int'(sdr0);
    n_udr <= n_udr + int'(udr0);
    n_rti <= n_rti + int'(rti0);
  end

  int cyc = 0, last0 = 0, last1 = 0, per0 = 0, per1 = 0, n_multi = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge tck0) begin per0 = cyc - last0; last0 = cyc; end
  always @(posedge tck1) begin per1 = cyc - last1; last1 = cyc; end
  always @(negedge clk)
    if ($countones({uir0, cdr0, sdr0, udr0, rti0}) > 1 ||
        $countones({uir1, cdr1, sdr1, udr1, rti1}) > 1) n_multi <= n_multi + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? h0.req_ready : h1.req_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 0) ? h0.rsp_valid : h1.rsp_valid;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [1:0] ir, input logic [SR_W-1:0] d);
    if (sel == 0) begin h0.req_valid = v; h0.req_ir = ir; h0.req_data = d; end
    else          begin h1.req_valid = v; h1.req_ir = ir; h1.req_data = d; end
  endtask

  // Entered and left at a negedge; returns after the accepting posedge.
  task automatic start_cmd(input int sel, input logic [1:0] ir, input logic [SR_W-1:0] d);
    int n = 0;
    set_req(sel, 1'b1, ir, d);
    while (!rdy(sel) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check_eq("accept_timeout", 64'(n), 64'(0));
    @(posedge clk);
    @(negedge clk);
    set_req(sel, 1'b0, ir, d);
  endtask

  task automatic wait_rsp(input int sel, output int lat);
    lat = 0;
    while (!vld(sel) && lat < 2000) begin @(posedge clk); lat++; @(negedge clk); end
  endtask

  task automatic finish_rsp(input int sel);
    if (sel == 0) h0.rsp_ready = 1'b1; else h1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) h0.rsp_ready = 1'b0; else h1.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, n, b_uir, b_cdr, b_sdr, b_udr, b_rti, n_busy, n_chg;
    logic [SR_W-1:0] snap;
    reset_n = 1'b0;
    set_req(0, 1'b0, 2'd0, '0); set_req(1, 1'b0, 2'd0, '0);
    h0.rsp_ready = 1'b0; h1.rsp_ready = 1'b0;
    tdo_tie = 1'b1; slv_init = '0; slv_load = 1'b1;
    #1 slv_load = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 64'(h0.req_ready), 64'(0));
    check_eq("rst_vji", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0, ir0}), 64'(0));
    check_eq("rst_rsp_valid", 64'(h0.rsp_valid), 64'(0));
    check_eq("rst_rsp_data", 64'(h0.rsp_data), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", 64'(h0.req_ready), 64'(1));

    // Single command, tdo tied high
    b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr; b_rti = n_rti;
    start_cmd(0, NIOS_DBG_IR_BREAK, 38'h2_AAAA_5555);
    check_eq("t1_ir_in", 64'(ir0), 64'(2));
    wait_rsp(0, lat);
    check_eq("t1_latency", 64'(lat), 64'(337));
    check_eq("t1_rsp_data", 64'(h0.rsp_data), 64'h3F_FFFF_FFFF);
    check_eq("t1_uir_periods", 64'(n_uir - b_uir), 64'(1));
    check_eq("t1_cdr_periods", 64'(n_cdr - b_cdr), 64'(1));
    check_eq("t1_sdr_periods", 64'(n_sdr - b_sdr), 64'(38));
    check_eq("t1_udr_periods", 64'(n_udr - b_udr), 64'(1));
    check_eq("t1_rti_periods", 64'(n_rti - b_rti), 64'(1));
    check_eq("t1_tdi_seq", 64'(slv_sr), 64'h2_AAAA_5555);
    check_eq("t1_tck_period", 64'(per0), 64'(8));
    check_eq("t1_resp_tck_low", 64'(tck0), 64'(0));
    finish_rsp(0);
    check_eq("t1_rsp_cleared", 64'(h0.rsp_valid), 64'(0));
    check_eq("t1_b2b_ready", 64'(h0.req_ready), 64'(1));

    // Loopback through the slave shift register
    slv_init = 38'h15_0000_00C3; slv_load = 1'b1;
    #1 slv_load = 1'b0;
    tdo_tie = 1'b0;
    start_cmd(0, NIOS_DBG_IR_OCIMEM, 38'h0A_1234_5678);
    wait_rsp(0, lat);
    check_eq("lb_latency", 64'(lat), 64'(337));
    check_eq("lb_rsp_data", 64'(h0.rsp_data), 64'h15_0000_00C3);
    check_eq("lb_slave_sr", 64'(slv_sr), 64'h0A_1234_5678);

    // Backpressure: response held, second request waiting
    set_req(0, 1'b1, NIOS_DBG_IR_OCIMEM, 38'h3_0F0F_F0F0);
    snap = h0.rsp_data; n_busy = 0; n_chg = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (h0.req_ready) n_busy++;
      if (h0.rsp_data !== snap || !h0.rsp_valid) n_chg++;
    end
    check_eq("bp_ready_low", 64'(n_busy), 64'(0));
    check_eq("bp_rsp_stable", 64'(n_chg), 64'(0));
    finish_rsp(0);
    check_eq("bp_rsp_dropped", 64'(h0.rsp_valid), 64'(0));
    check_eq("bp_ready_next", 64'(h0.req_ready), 64'(1));
    b_uir = n_uir;
    start_cmd(0, NIOS_DBG_IR_OCIMEM, 38'h3_0F0F_F0F0);
    wait_rsp(0, lat);
    check_eq("bp_latency", 64'(lat), SKIP ? 64'(329) : 64'(337));
    check_eq("bp_uir_periods", 64'(n_uir - b_uir), SKIP ? 64'(0) : 64'(1));
    check_eq("bp_rsp_data", 64'(h0.rsp_data), 64'h0A_1234_5678);
    check_eq("bp_slave_sr", 64'(slv_sr), 64'h3_0F0F_F0F0);
    finish_rsp(0);

    // IR change always performs UIR
    tdo_tie = 1'b1;
    b_uir = n_uir;
    start_cmd(0, NIOS_DBG_IR_TRACEMEM, 38'h1F_0000_0001);
    wait_rsp(0, lat);
    check_eq("irc_latency", 64'(lat), 64'(337));
    check_eq("irc_uir_periods", 64'(n_uir - b_uir), 64'(1));
    check_eq("irc_slave_sr", 64'(slv_sr), 64'h1F_0000_0001);
    finish_rsp(0);

    // Reset in the middle of SDR
    b_sdr = n_sdr; n = 0;
    start_cmd(0, NIOS_DBG_IR_TRACECTRL, 38'h00_0000_002A);
    while ((n_sdr - b_sdr) < 17 && n < 1000) begin @(negedge clk); n++; end
    check_eq("mid_sdr_bit", 64'(n_sdr - b_sdr), 64'(17));
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_vji", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0, ir0}), 64'(0));
    check_eq("mid_rst_rsp_valid", 64'(h0.rsp_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rdy_after_rst", 64'(h0.req_ready), 64'(1));
    start_cmd(0, NIOS_DBG_IR_TRACECTRL, 38'h11_2233_4455);
    wait_rsp(0, lat);
    check_eq("post_rst_latency", 64'(lat), 64'(337));
    check_eq("post_rst_rsp_data", 64'(h0.rsp_data), 64'h3F_FFFF_FFFF);
    finish_rsp(0);

    // TCK_DIV=1 instance
    start_cmd(1, NIOS_DBG_IR_BREAK, 38'h00_0000_0005);
    check_eq("fast_ir_in", 64'(ir1), 64'(2));
    wait_rsp(1, lat);
    check_eq("fast_latency", 64'(lat), 64'(85));
    check_eq("fast_tck_period", 64'(per1), 64'(2));
    check_eq("fast_rsp_data", 64'(h1.rsp_data), 64'h3F_FFFF_FFFF);
    finish_rsp(1);
    check_eq("fast_b2b_ready", 64'(h1.req_ready), 64'(1));

    check_eq("flags_one_hot", 64'(n_multi), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
